// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: the instruction-memory request/response channel,
// the decode-side handshake and the execute redirect.
// master = the fetch unit, slave = its environment (memory, decode, execute).
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr,
        output fetch_valid, fetch_instr, fetch_pc, fetch_pc_plus4,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  stall_d, redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  fetch_valid, fetch_instr, fetch_pc, fetch_pc_plus4,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output stall_d, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order credit-limited requests
// to variable-latency instruction memory, buffers responses in a small FIFO and
// hands {instr, pc, pc+4} to decode. Redirects flush the FIFO and discard the
// responses still in flight.
// Optional perf counters are compiled in when IFETCH_PERF_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter int          CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_unit_if.master    bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [CNT_W-1:0]      perf_fetched,
    output logic [CNT_W-1:0]      perf_dropped,
    output logic [CNT_W-1:0]      perf_stall
`endif
);
    localparam int PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_BITS = $clog2(BUF_DEPTH + 1);

    // PC, credit bookkeeping and FIFO / PC-queue pointers
    logic [31:0]         pc_reg;
    logic [CNT_BITS-1:0] out_cnt_reg;
    logic [CNT_BITS-1:0] drop_cnt_reg;
    logic [CNT_BITS-1:0] fifo_cnt_reg;
    logic [PTR_W-1:0]    fifo_wr_reg;
    logic [PTR_W-1:0]    fifo_rd_reg;
    logic [PTR_W-1:0]    pcq_wr_reg;
    logic [PTR_W-1:0]    pcq_rd_reg;

    // Storage is not reset: validity is tracked purely by the counters.
    logic [31:0] fifo_instr_mem [BUF_DEPTH];
    logic [31:0] fifo_pc_mem    [BUF_DEPTH];
    logic [31:0] pcq_mem        [BUF_DEPTH];

    logic [CNT_BITS:0] in_use;
    logic              credit_ok;
    logic              req_valid;
    logic              req_fire;
    logic              resp_fire;
    logic              resp_drop;
    logic              push;
    logic              pop;
    logic              fifo_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake decode: credit check, response accept/drop, FIFO push/pop
    always_comb begin
        in_use     = {1'b0, out_cnt_reg} + {1'b0, fifo_cnt_reg};
        credit_ok  = in_use < (CNT_BITS + 1)'(BUF_DEPTH);
        fifo_empty = (fifo_cnt_reg == '0);
        // Gated by rst so the request line reads 0 while reset is held.
        req_valid  = rst && !bus.redirect && (drop_cnt_reg == '0) && credit_ok;
        req_fire   = req_valid && bus.imem_req_ready;
        // A response with nothing outstanding is a protocol error; ignore it.
        resp_fire  = bus.imem_resp_valid && (out_cnt_reg != '0);
        resp_drop  = resp_fire && ((drop_cnt_reg != '0) || bus.redirect);
        push       = resp_fire && !resp_drop;
        pop        = !fifo_empty && !bus.stall_d && !bus.redirect;
    end

    // Output presentation straight from the FIFO head, zero when empty
    always_comb begin
        bus.imem_req_valid = req_valid;
        bus.imem_req_addr  = pc_reg;
        bus.fetch_valid    = !fifo_empty;
        bus.fetch_instr    = fifo_empty ? 32'h0 : fifo_instr_mem[fifo_rd_reg];
        bus.fetch_pc       = fifo_empty ? 32'h0 : fifo_pc_mem[fifo_rd_reg];
        bus.fetch_pc_plus4 = fifo_empty ? 32'h0 : fifo_pc_mem[fifo_rd_reg] + 32'd4;
    end

    // Control state: PC, outstanding/drop credits, FIFO and PC-queue pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg       <= RESET_PC;
            out_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
            fifo_cnt_reg <= '0;
            fifo_wr_reg  <= '0;
            fifo_rd_reg  <= '0;
            pcq_wr_reg   <= '0;
            pcq_rd_reg   <= '0;
        end else begin
            // The PC queue tracks every in-flight request, stale or not, so it
            // advances on every response even across a redirect.
            out_cnt_reg <= out_cnt_reg + CNT_BITS'(req_fire) - CNT_BITS'(resp_fire);
            if (req_fire) begin
                pcq_wr_reg <= ptr_inc(pcq_wr_reg);
            end
            if (resp_fire) begin
                pcq_rd_reg <= ptr_inc(pcq_rd_reg);
            end

            if (bus.redirect) begin
                pc_reg       <= {bus.redirect_pc[31:2], 2'b00};
                fifo_cnt_reg <= '0;
                fifo_wr_reg  <= '0;
                fifo_rd_reg  <= '0;
                // Everything still outstanding after this cycle is stale.
                drop_cnt_reg <= out_cnt_reg - CNT_BITS'(resp_fire);
            end else begin
                if (req_fire) begin
                    pc_reg <= pc_reg + 32'd4;
                end
                if (resp_drop) begin
                    drop_cnt_reg <= drop_cnt_reg - CNT_BITS'(1);
                end
                if (push) begin
                    fifo_wr_reg <= ptr_inc(fifo_wr_reg);
                end
                if (pop) begin
                    fifo_rd_reg <= ptr_inc(fifo_rd_reg);
                end
                if (push && !pop) begin
                    fifo_cnt_reg <= fifo_cnt_reg + CNT_BITS'(1);
                end else if (pop && !push) begin
                    fifo_cnt_reg <= fifo_cnt_reg - CNT_BITS'(1);
                end
            end
        end
    end

    // Data storage writes: request PCs into the PC queue, responses into the FIFO
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_mem[pcq_wr_reg] <= pc_reg;
        end
        if (push) begin
            fifo_instr_mem[fifo_wr_reg] <= bus.imem_resp_data;
            fifo_pc_mem[fifo_wr_reg]    <= pcq_mem[pcq_rd_reg];
        end
    end

`ifdef IFETCH_PERF_EN
    // Free-running wrap-around perf counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + CNT_W'(1);
            end
            if (resp_drop) begin
                perf_dropped <= perf_dropped + CNT_W'(1);
            end
            if (fifo_empty && !bus.redirect) begin
                perf_stall <= perf_stall + CNT_W'(1);
            end
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: in-order variable-latency memory model plus
// an architectural scoreboard (expected request/fetch PC streams restarting at
// each redirect target). Perf counters are checked when IFETCH_PERF_EN is set.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic clk;
    logic rst;
    instr_fetch_unit_if bus ();
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif

    instr_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped),
        .perf_stall   (perf_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // memory model state
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    bit          mq_stale[$];
    int          last_due;
    int          lat;
    bit          resp_gate;
    int          cyc;

    // architectural expectations
    logic [31:0] exp_req_pc, exp_fetch_pc;
    int          exp_fetched, exp_dropped, exp_stall;
    bit          prev_redirect, prev_held, prev_blocked;
    int          first_acc, first_valid, n_pops;
    logic [31:0] first_pops [3];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mq_addr.delete();
        mq_due.delete();
        mq_stale.delete();
        last_due      = cyc;
        exp_req_pc    = RESET_PC;
        exp_fetch_pc  = RESET_PC;
        exp_fetched   = 0;
        exp_dropped   = 0;
        exp_stall     = 0;
        prev_redirect = 0;
        prev_held     = 0;
        prev_blocked  = 0;
        first_acc     = -1;
        first_valid   = -1;
        n_pops        = 0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'h0);
        chk({tag, "_fetch_valid"}, 32'(bus.fetch_valid), 32'h0);
        chk({tag, "_fetch_instr"}, bus.fetch_instr, 32'h0);
        chk({tag, "_fetch_pc"}, bus.fetch_pc, 32'h0);
        chk({tag, "_fetch_pc_plus4"}, bus.fetch_pc_plus4, 32'h0);
    endtask

    // One clock cycle: caller has set stall_d/redirect/redirect_pc/ready.
    task automatic step();
        bit resp_now, accept, pop_ev;
        int due;
        resp_now = (mq_addr.size() > 0) && (mq_due[0] <= cyc) && resp_gate;
        bus.imem_resp_valid = resp_now;
        bus.imem_resp_data  = resp_now ? mem_word(mq_addr[0]) : $urandom();
        #1;
        if (prev_redirect) chk("flush_valid", 32'(bus.fetch_valid), 32'h0);
        if (bus.redirect) chk("redirect_no_req", 32'(bus.imem_req_valid), 32'h0);
        if (prev_held && !bus.redirect) begin
            chk("held_valid", 32'(bus.imem_req_valid), 32'h1);
            chk("held_addr", bus.imem_req_addr, exp_req_pc);
        end
        if (prev_blocked) begin
            chk("head_valid", 32'(bus.fetch_valid), 32'h1);
            chk("head_pc", bus.fetch_pc, exp_fetch_pc);
            chk("head_instr", bus.fetch_instr, mem_word(exp_fetch_pc));
        end
        accept = bus.imem_req_valid && bus.imem_req_ready;
        if (accept) begin
            chk("req_addr", bus.imem_req_addr, exp_req_pc);
            if (first_acc < 0) first_acc = cyc;
            exp_req_pc = exp_req_pc + 32'd4;
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            mq_addr.push_back(bus.imem_req_addr);
            mq_due.push_back(due);
            mq_stale.push_back(1'b0);
        end
        if (bus.fetch_valid && first_valid < 0) first_valid = cyc;
        pop_ev = bus.fetch_valid && !bus.stall_d && !bus.redirect;
        if (pop_ev) begin
            chk("fetch_pc", bus.fetch_pc, exp_fetch_pc);
            chk("fetch_instr", bus.fetch_instr, mem_word(exp_fetch_pc));
            chk("fetch_pc_plus4", bus.fetch_pc_plus4, exp_fetch_pc + 32'd4);
            if (n_pops < 3) first_pops[n_pops] = bus.fetch_pc;
            n_pops++;
            exp_fetch_pc = exp_fetch_pc + 32'd4;
            exp_fetched++;
        end
        if (!bus.fetch_valid && !bus.redirect) exp_stall++;
        if (bus.redirect) begin
            foreach (mq_stale[i]) mq_stale[i] = 1'b1;
            exp_req_pc   = {bus.redirect_pc[31:2], 2'b00};
            exp_fetch_pc = {bus.redirect_pc[31:2], 2'b00};
        end
        if (resp_now) begin
            if (mq_stale[0]) exp_dropped++;
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
            void'(mq_stale.pop_front());
        end
        prev_held     = bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect;
        prev_blocked  = bus.fetch_valid && bus.stall_d && !bus.redirect;
        prev_redirect = bus.redirect;
        @(posedge clk);
        cyc++;
        #1;
`ifdef IFETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'(exp_fetched));
        chk("perf_dropped", perf_dropped, 32'(exp_dropped));
        chk("perf_stall", perf_stall, 32'(exp_stall));
`endif
    endtask

    task automatic redirect_to(input logic [31:0] target);
        bus.redirect    = 1'b1;
        bus.redirect_pc = target;
        step();
        bus.redirect    = 1'b0;
        bus.redirect_pc = $urandom();
    endtask

    task automatic wait_outstanding(input int n, input string tag);
        int guard;
        guard = 0;
        while (mq_addr.size() < n && guard < 40) begin
            step();
            guard++;
        end
        chk(tag, 32'(mq_addr.size() >= n), 32'h1);
    endtask

    initial begin
        cyc = 0;
        rst = 1'b0;
        lat = 1;
        resp_gate = 1'b1;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.stall_d         = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_pc     = 32'h0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b1;
        model_reset();

        // streaming, ready always, latency 1
        repeat (12) step();
        chk("first_latency", 32'(first_valid - first_acc), 32'd2);
        for (int i = 0; i < 3; i++)
            chk("first_pops", first_pops[i], RESET_PC + 32'(4 * i));

        // decode stall: buffer fills, credit stops requests, head held
        bus.stall_d = 1'b1;
        repeat (5) step();
        chk("stall_no_req", 32'(bus.imem_req_valid), 32'h0);
        chk("stall_full_valid", 32'(bus.fetch_valid), 32'h1);
        bus.stall_d = 1'b0;
        repeat (10) step();

        // redirect with two responses in flight at latency 3
        lat = 3;
        wait_outstanding(2, "two_outstanding");
        redirect_to(32'h0000_0100);
        repeat (15) step();

        // redirect while stalled with a full buffer
        lat = 1;
        bus.stall_d = 1'b1;
        repeat (6) step();
        redirect_to(32'h0000_0200);
        step();
        bus.stall_d = 1'b0;
        repeat (10) step();

        // misaligned target, then wrap past the top of the address space
        redirect_to(32'h0000_0103);
        repeat (8) step();
        redirect_to(32'hFFFF_FFF4);
        repeat (14) step();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c % 50 == 0) lat = $urandom_range(1, 4);
            bus.stall_d        = ($urandom_range(0, 3) == 0);
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            resp_gate          = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 19) == 0) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                               : $urandom();
            end else begin
                bus.redirect = 1'b0;
            end
            step();
        end
        bus.redirect       = 1'b0;
        bus.stall_d        = 1'b0;
        bus.imem_req_ready = 1'b1;
        resp_gate          = 1'b1;
        repeat (20) step();

        // asynchronous reset mid-stream with two requests outstanding
        lat = 3;
        redirect_to(32'h0000_0040);
        wait_outstanding(2, "two_outstanding_rst");
        bus.imem_resp_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        @(posedge clk);
        cyc++;
        #1;
        model_reset();
        rst = 1'b1;
        lat = 1;
        repeat (10) step();
        chk("post_reset_first_pc", first_pops[0], RESET_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
